// File: rtl/leaf_arb_pkg.sv
// Shared definitions for the leaf output arbiter: packet field layout and destination entry.
// No logic; constants and types only.
// Field offsets describe the 49-bit BFT packet {valid, leaf, port, addr, payload}.
package leaf_arb_pkg;

    localparam int LEAF_BITS  = 5;
    localparam int PORT_BITS  = 4;

    localparam int VALID_BIT  = 48;
    localparam int LEAF_LSB   = 43;
    localparam int PORT_LSB   = 39;
    localparam int ADDR_LSB   = 32;

    // Downstream BRAM depth; a port may have this many packets outstanding.
    localparam int CREDIT_MAX = 128;

    typedef struct packed {
        logic [LEAF_BITS-1:0] leaf;
        logic [PORT_BITS-1:0] port;
    } dest_entry;

    // Index width for a requester count, never below one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/leaf_out_arbiter_rr_grant.sv
// Round-robin priority encoder: first set request at or after the pointer, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller masks requests it cannot serve.
module rr_grant #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic [IW:0]   w_sum;
    logic [IW-1:0] w_cand;

    // Walk candidates ptr, ptr+1, ... modulo N and latch the first requester.
    always_comb begin
        o_gnt  = '0;
        o_idx  = '0;
        o_any  = 1'b0;
        w_sum  = '0;
        w_cand = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_cand = w_sum[IW-1:0];
            if (!o_any && i_req[w_cand]) begin
                o_any         = 1'b1;
                o_gnt[w_cand] = 1'b1;
                o_idx         = w_cand;
            end
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// Round-robin, credit-gated scheduler of user output streams onto one BFT packet lane.
// Latency: ack is combinational; the packet is registered one cycle after the vld&&ack handshake.
// Backpressure: !tx_ready or resend withholds every ack and freezes state; credit updates still land.
// Optional build macro ARB_STATS_EN adds per-port sent counters and a stall counter on stats_bus.
module leaf_out_arbiter
    import leaf_arb_pkg::*;
#(
    parameter int NUM_OUT_PORTS         = 4,
    parameter int PAYLOAD_BITS          = 32,
    parameter int NUM_LEAF_BITS         = 5,
    parameter int NUM_PORT_BITS         = 4,
    parameter int NUM_ADDR_BITS         = 7,
    parameter int FREESPACE_UPDATE_SIZE = 64,
    parameter int PACKET_BITS           = 49
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user2arb,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2arb,
    output logic [NUM_OUT_PORTS-1:0]                ack_arb2user,
    input  logic [NUM_OUT_PORTS-1:0]                credit_upd,
    input  logic                                    cfg_we,
    input  logic [2:0]                              cfg_sel,
    input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]  cfg_dest,
    input  logic                                    tx_ready,
    input  logic                                    resend,
    output logic [PACKET_BITS-1:0]                  dout_arb2bft
`ifdef ARB_STATS_EN
    ,
    output logic [(NUM_OUT_PORTS+1)*16-1:0]         stats_bus
`endif
);

    localparam int IW = idx_width(NUM_OUT_PORTS);
    localparam int CW = NUM_ADDR_BITS + 1;
    localparam int SW = NUM_ADDR_BITS + 3;

    dest_entry                r_dest   [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] r_addr   [NUM_OUT_PORTS];
    logic [CW-1:0]            r_credit [NUM_OUT_PORTS];
    logic [IW-1:0]            r_ptr;
    logic [PACKET_BITS-1:0]   r_dout;

    logic [NUM_OUT_PORTS-1:0] w_req;
    logic [NUM_OUT_PORTS-1:0] w_gnt;
    logic [IW-1:0]            w_idx;
    logic                     w_any;
    logic [IW-1:0]            w_ptr_nxt;
    logic [PACKET_BITS-1:0]   w_pkt;
    logic [CW-1:0]            w_credit_nxt [NUM_OUT_PORTS];
    logic [SW-1:0]            w_csum;
    logic                     w_cfg_hit;

    // A port competes only with data, credit, an open lane and reset released.
    always_comb begin
        w_req = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            w_req[i] = reset_n && vld_user2arb[i] && (r_credit[i] != '0) && tx_ready && !resend;
        end
    end

    rr_grant #(
        .N  (NUM_OUT_PORTS),
        .IW (IW)
    ) u_rr_grant (
        .i_req (w_req),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign ack_arb2user = w_gnt;
    assign dout_arb2bft = r_dout;
    assign w_ptr_nxt    = (w_idx == IW'(NUM_OUT_PORTS - 1)) ? '0 : w_idx + 1'b1;
    assign w_cfg_hit    = cfg_we && (int'(cfg_sel) < NUM_OUT_PORTS);

    // Assemble the granted port's packet from its current (pre-write) table entry and address.
    always_comb begin
        w_pkt                            = '0;
        w_pkt[VALID_BIT]                 = 1'b1;
        w_pkt[LEAF_LSB +: LEAF_BITS]     = r_dest[w_idx].leaf;
        w_pkt[PORT_LSB +: PORT_BITS]     = r_dest[w_idx].port;
        w_pkt[ADDR_LSB +: NUM_ADDR_BITS] = r_addr[w_idx];
        w_pkt[0 +: PAYLOAD_BITS]         = din_user2arb[int'(w_idx)*PAYLOAD_BITS +: PAYLOAD_BITS];
    end

    // Credit: +update, -grant, clamped at the destination depth; zero-credit ports never grant.
    always_comb begin
        w_csum = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            w_csum = SW'(r_credit[i])
                   + (credit_upd[i] ? SW'(FREESPACE_UPDATE_SIZE) : SW'(0))
                   - (w_gnt[i] ? SW'(1) : SW'(0));
            w_credit_nxt[i] = (w_csum > SW'(CREDIT_MAX)) ? CW'(CREDIT_MAX) : CW'(w_csum);
        end
    end

    // Output register: one packet per grant, all-zero otherwise; reset drops any in-flight packet.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_dout <= '0;
        end else begin
            r_dout <= w_any ? w_pkt : '0;
        end
    end

    // Pointer moves past the winner; it holds on idle or stalled cycles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Per-port destination address and credit bookkeeping.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (!reset_n) begin
                r_addr[i]   <= '0;
                r_credit[i] <= CW'(CREDIT_MAX);
            end else begin
                if (w_gnt[i]) begin
                    r_addr[i] <= r_addr[i] + 1'b1;
                end
                r_credit[i] <= w_credit_nxt[i];
            end
        end
    end

    // Destination table; out-of-range selects are dropped, and config is not gated by lane stalls.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                r_dest[i] <= '0;
            end
        end else if (w_cfg_hit) begin
            r_dest[cfg_sel[IW-1:0]] <= cfg_dest;
        end
    end

`ifdef ARB_STATS_EN
    logic [15:0] r_sent [NUM_OUT_PORTS];
    logic [15:0] r_stall;

    // Wrapping per-port sent counters and a stall counter for cycles with demand but no grant.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                r_sent[i] <= '0;
            end
            r_stall <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                if (w_gnt[i]) begin
                    r_sent[i] <= r_sent[i] + 16'd1;
                end
            end
            if ((|vld_user2arb) && !w_any) begin
                r_stall <= r_stall + 16'd1;
            end
        end
    end

    // Stall counter occupies the top 16 bits, port counters below in port order.
    always_comb begin
        stats_bus = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            stats_bus[i*16 +: 16] = r_sent[i];
        end
        stats_bus[NUM_OUT_PORTS*16 +: 16] = r_stall;
    end
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
`timescale 1ns/1ps
module tb_leaf_out_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N*32-1:0] din;
    logic [N-1:0]   vld;
    logic [N-1:0]   ack;
    logic [N-1:0]   upd;
    logic           cfg_we;
    logic [2:0]     cfg_sel;
    logic [8:0]     cfg_dest;
    logic           tx_ready;
    logic           resend;
    logic [48:0]    dout;
`ifdef ARB_STATS_EN
    logic [(N+1)*16-1:0] stats_bus;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    leaf_out_arbiter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .din_user2arb (din),
        .vld_user2arb (vld),
        .ack_arb2user (ack),
        .credit_upd   (upd),
        .cfg_we       (cfg_we),
        .cfg_sel      (cfg_sel),
        .cfg_dest     (cfg_dest),
        .tx_ready     (tx_ready),
        .resend       (resend),
        .dout_arb2bft (dout)
`ifdef ARB_STATS_EN
        ,
        .stats_bus    (stats_bus)
`endif
    );

    typedef struct {
        logic [3:0] v;
        logic       txr;
        logic       rs;
        logic       we;
        logic [2:0] sel;
        logic [8:0] d;
        logic [3:0] eack;
        logic [48:0] edout;
    } vec_t;

    vec_t tbl [20];

    function automatic logic [31:0] pay(input int i);
        return 32'(i + 1) * 32'h1000_0001;
    endfunction

    function automatic logic [48:0] pkt(input logic [4:0] leaf, input logic [3:0] port,
                                        input logic [6:0] addr, input logic [31:0] p);
        return {1'b1, leaf, port, addr, p};
    endfunction

    function automatic vec_t row(input logic [3:0] v, input logic txr, input logic rs,
                                 input logic we, input logic [2:0] sel, input logic [8:0] d,
                                 input logic [3:0] eack, input logic [4:0] el, input logic [3:0] ep,
                                 input logic [6:0] ea, input int pidx);
        vec_t r;
        r.v = v; r.txr = txr; r.rs = rs; r.we = we; r.sel = sel; r.d = d; r.eack = eack;
        r.edout = (eack == 4'b0000) ? 49'd0 : pkt(el, ep, ea, pay(pidx));
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] u, input logic txr, input logic rs,
                         input logic we, input logic [2:0] sel, input logic [8:0] d);
        @(negedge clk);
        vld = v; upd = u; tx_ready = txr; resend = rs;
        cfg_we = we; cfg_sel = sel; cfg_dest = d;
        #1;
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    // One cycle: apply inputs, check the combinational ack, then the registered packet.
    task automatic step(input string nm, input logic [3:0] v, input logic [3:0] u,
                        input logic txr, input logic rs, input logic we, input logic [2:0] sel,
                        input logic [8:0] d, input logic [3:0] eack, input logic [48:0] edout);
        drive(v, u, txr, rs, we, sel, d);
        chk({nm, "_ack"}, 64'(ack), 64'(eack));
        clk_edge();
        chk({nm, "_dout"}, 64'(dout), 64'(edout));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0);
        clk_edge();
        reset_n = 1'b1;
    endtask

    task automatic cfg(input logic [2:0] sel, input logic [4:0] leaf, input logic [3:0] port);
        drive(4'h0, 4'h0, 1'b1, 1'b0, 1'b1, sel, {leaf, port});
        clk_edge();
    endtask

    // Stream one port against a credit/address model for a fixed number of cycles.
    task automatic stream(input string nm, input int pidx, input int cycles, input int credit0,
                          input logic [6:0] addr0, input logic [4:0] leaf, input logic [3:0] port);
        int cm;
        logic [6:0] am;
        logic [3:0] onehot;
        cm = credit0;
        am = addr0;
        onehot = 4'b0001 << pidx;
        for (int s = 0; s < cycles; s++) begin
            step(nm, onehot, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,
                 (cm != 0) ? onehot : 4'h0,
                 (cm != 0) ? pkt(leaf, port, am, pay(pidx)) : 49'd0);
            if (cm != 0) begin
                cm--;
                am = am + 7'd1;
            end
        end
    endtask

    initial begin
        din      = {pay(3), pay(2), pay(1), pay(0)};
        vld      = '0;
        upd      = '0;
        cfg_we   = 1'b0;
        cfg_sel  = '0;
        cfg_dest = '0;
        tx_ready = 1'b1;
        resend   = 1'b0;
        reset_n  = 1'b0;

        // Reset state, with requests already asserted.
        drive(4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0);
        chk("reset_ack", 64'(ack), 64'd0);
        clk_edge();
        chk("reset_dout", 64'(dout), 64'd0);
        reset_n = 1'b1;
        drive(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0);
        clk_edge();
        chk("post_reset_dout", 64'(dout), 64'd0);

        cfg(3'd0, 5'd3, 4'd2);
        cfg(3'd1, 5'd5, 4'd1);
        cfg(3'd2, 5'd17, 4'd9);
        cfg(3'd3, 5'd31, 4'd15);

        //              vld     txr   rs    we    sel   dest               ack      leaf   port   addr  pidx
        tbl[0]  = row(4'b0000, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b0000, 5'd0,  4'd0,  7'd0, 0);
        tbl[1]  = row(4'b0001, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b0001, 5'd3,  4'd2,  7'd0, 0);
        tbl[2]  = row(4'b0001, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b0001, 5'd3,  4'd2,  7'd1, 0);
        tbl[3]  = row(4'b1111, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b0010, 5'd5,  4'd1,  7'd0, 1);
        tbl[4]  = row(4'b1111, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b0100, 5'd17, 4'd9,  7'd0, 2);
        tbl[5]  = row(4'b1111, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b1000, 5'd31, 4'd15, 7'd0, 3);
        tbl[6]  = row(4'b1111, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b0001, 5'd3,  4'd2,  7'd2, 0);
        tbl[7]  = row(4'b1111, 1'b1, 1'b1, 1'b0, 3'd0, 9'd0,              4'b0000, 5'd0,  4'd0,  7'd0, 0);
        tbl[8]  = row(4'b1111, 1'b0, 1'b0, 1'b0, 3'd0, 9'd0,              4'b0000, 5'd0,  4'd0,  7'd0, 0);
        tbl[9]  = row(4'b1111, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b0010, 5'd5,  4'd1,  7'd1, 1);
        tbl[10] = row(4'b1001, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b1000, 5'd31, 4'd15, 7'd1, 3);
        tbl[11] = row(4'b0110, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b0010, 5'd5,  4'd1,  7'd2, 1);
        tbl[12] = row(4'b0000, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b0000, 5'd0,  4'd0,  7'd0, 0);
        tbl[13] = row(4'b0011, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b0001, 5'd3,  4'd2,  7'd3, 0);
        tbl[14] = row(4'b0100, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b0100, 5'd17, 4'd9,  7'd1, 2);
        tbl[15] = row(4'b0001, 1'b1, 1'b0, 1'b1, 3'd0, {5'd7, 4'd7},      4'b0001, 5'd3,  4'd2,  7'd4, 0);
        tbl[16] = row(4'b0001, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b0001, 5'd7,  4'd7,  7'd5, 0);
        tbl[17] = row(4'b0001, 1'b1, 1'b0, 1'b1, 3'd7, {5'd1, 4'd1},      4'b0001, 5'd7,  4'd7,  7'd6, 0);
        tbl[18] = row(4'b1000, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b1000, 5'd31, 4'd15, 7'd2, 3);
        tbl[19] = row(4'b1111, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0,              4'b0001, 5'd7,  4'd7,  7'd7, 0);

        for (int r = 0; r < 20; r++) begin
            step($sformatf("row%0d", r), tbl[r].v, 4'h0, tbl[r].txr, tbl[r].rs,
                 tbl[r].we, tbl[r].sel, tbl[r].d, tbl[r].eack, tbl[r].edout);
        end

        // Resend hold: pointer parked at 2 must survive five blocked cycles.
        do_reset();
        step("rs_pre0", 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0, 4'b0001, pkt(5'd0, 4'd0, 7'd0, pay(0)));
        step("rs_pre1", 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0, 4'b0010, pkt(5'd0, 4'd0, 7'd0, pay(1)));
        for (int s = 0; s < 5; s++) begin
            step("rs_hold", 4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 3'd0, 9'd0, 4'b0000, 49'd0);
        end
        step("rs_release", 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0, 4'b0100, pkt(5'd0, 4'd0, 7'd0, pay(2)));
        step("rs_next", 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0, 4'b1000, pkt(5'd0, 4'd0, 7'd0, pay(3)));

        // Reset while streaming: in-flight packet dropped, pointer/addresses cleared.
        reset_n = 1'b0;
        drive(4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0);
        chk("midrst_ack", 64'(ack), 64'd0);
        clk_edge();
        chk("midrst_dout", 64'(dout), 64'd0);
        reset_n = 1'b1;
        cfg(3'd7, 5'd9, 4'd9);
        step("after_rst", 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0, 4'b0001, pkt(5'd0, 4'd0, 7'd0, pay(0)));
        step("cfg_sel7", 4'b1000, 4'h0, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0, 4'b1000, pkt(5'd0, 4'd0, 7'd0, pay(3)));

        // Drain port 0: 128 beats with wrapping address, then credit return of 64.
        do_reset();
        cfg(3'd0, 5'd3, 4'd2);
        stream("drain", 0, 135, 128, 7'd0, 5'd3, 4'd2);
        step("upd_pulse", 4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0, 4'b0000, 49'd0);
        stream("refill", 0, 70, 64, 7'd0, 5'd3, 4'd2);

        // Grant and update together at credit 100 must clamp to 128.
        do_reset();
        stream("sat_pre", 1, 28, 128, 7'd0, 5'd0, 4'd0);
        step("sat_both", 4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0, 3'd0, 9'd0, 4'b0010,
             pkt(5'd0, 4'd0, 7'd28, pay(1)));
        stream("sat_post", 1, 135, 128, 7'd29, 5'd0, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
